tx_frame_fifo: RTL and testbench

Frame-oriented byte buffer directly upstream of the TX control stage. The bridge ingress side writes bytes, and a frame is committed to the queue when its last byte is written. The block presents the length of the oldest committed frame and supplies its bytes one per nextByte strobe. Frames that overflow the buffer are dropped whole, so the downstream stage only ever sees complete frames.

---
 rtl/tx_frame_fifo.sv | 180 ++++++++++++++++++
 tb/tb_tx_frame_fifo.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_fifo.sv
// Frame-oriented byte buffer feeding the TX control stage. Ingress bytes are
// stored as they arrive; a frame only becomes visible downstream once its last
// byte commits its length into a small length queue. Frames that cannot fit
// while nothing else is queued are dropped whole.
module tx_frame_fifo #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LEN_Q_W = 2,
    parameter int unsigned MIN_LEN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       wr_data,
    input  logic             wr_valid,
    input  logic             wr_last,
    output logic             wr_ready,
    output logic             drop,
    input  logic             nextByte,
    output logic [7:0]       tx_data,
    output logic [15:0]      frm_len,
    output logic             empty_buff,
    input  logic             frm_done,
    output logic [LEN_Q_W:0] frm_count
);

    localparam int unsigned Depth   = 1 << ADDR_W;
    localparam int unsigned LqDepth = 1 << LEN_Q_W;

    typedef enum logic [1:0] {StIdle, StFill, StDiscard} wr_state_e;

    wr_state_e state_q, state_d;

    logic [7:0]         mem [Depth];
    logic [15:0]        lenq_q [LqDepth];

    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  frame_start_q, frame_start_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    // Bytes held in RAM: committed frames plus the frame being written.
    logic [ADDR_W:0]    used_q, used_d;
    logic [ADDR_W:0]    rewind_len;
    logic [15:0]        cur_len_q, cur_len_d, new_len;
    // Bytes of the head frame already handed out; remaining = frm_len - rd_cnt.
    logic [15:0]        rd_cnt_q, rd_cnt_d, rd_remain;
    logic [LEN_Q_W-1:0] lq_wr_q, lq_wr_d, lq_rd_q, lq_rd_d;
    logic [LEN_Q_W:0]   frm_count_q, frm_count_d;
    logic [7:0]         tx_data_q;

    logic accept, store, push, pop, rd_en;
    logic data_full, lenq_full, lenq_empty, overflow;

    // used_q never exceeds Depth, so its top bit alone flags a full RAM.
    assign data_full  = used_q[ADDR_W];
    assign lenq_full  = frm_count_q[LEN_Q_W];
    assign lenq_empty = (frm_count_q == '0);
    assign overflow   = (state_q == StFill) && data_full && lenq_empty;
    assign wr_ready   = (state_q == StDiscard) ? 1'b1 : (!data_full && !lenq_full);
    assign accept     = wr_valid && wr_ready;
    assign new_len    = cur_len_q + 16'd1;

    assign frm_len    = lenq_empty ? 16'd0 : lenq_q[lq_rd_q];
    assign empty_buff = lenq_empty;
    assign frm_count  = frm_count_q;
    assign tx_data    = tx_data_q;
    assign rd_remain  = frm_len - rd_cnt_q;
    assign pop        = frm_done && !lenq_empty;
    assign rd_en      = nextByte && !lenq_empty && (rd_remain != 16'd0);

    // Write FSM: store, commit, drop-and-rewind decisions.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        frame_start_d = frame_start_q;
        cur_len_d     = cur_len_q;
        rewind_len    = '0;
        store         = 1'b0;
        push          = 1'b0;
        drop          = 1'b0;
        case (state_q)
            StIdle, StFill: begin
                if (overflow) begin
                    drop       = 1'b1;
                    wr_ptr_d   = frame_start_q;
                    cur_len_d  = '0;
                    rewind_len = cur_len_q[ADDR_W:0];
                    state_d    = StDiscard;
                end else if (accept) begin
                    if (wr_last && (new_len < 16'(MIN_LEN))) begin
                        drop       = 1'b1;
                        wr_ptr_d   = frame_start_q;
                        cur_len_d  = '0;
                        rewind_len = cur_len_q[ADDR_W:0];
                        state_d    = StIdle;
                    end else begin
                        store    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (wr_last) begin
                            push          = 1'b1;
                            cur_len_d     = '0;
                            frame_start_d = wr_ptr_q + 1'b1;
                            state_d       = StIdle;
                        end else begin
                            cur_len_d = new_len;
                            state_d   = StFill;
                        end
                    end
                end
            end
            StDiscard: begin
                if (accept && wr_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Read pointer, length queue pointers and occupancy bookkeeping.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        rd_cnt_d = rd_cnt_q;
        if (pop) begin
            // Skip whatever the consumer left unread in the popped frame.
            rd_ptr_d = rd_ptr_q + rd_remain[ADDR_W-1:0];
            rd_cnt_d = '0;
        end else if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
        lq_wr_d     = lq_wr_q + {{(LEN_Q_W-1){1'b0}}, push};
        lq_rd_d     = lq_rd_q + {{(LEN_Q_W-1){1'b0}}, pop};
        frm_count_d = frm_count_q + {{LEN_Q_W{1'b0}}, push} - {{LEN_Q_W{1'b0}}, pop};
        used_d      = used_q + {{ADDR_W{1'b0}}, store}
                      - (pop ? frm_len[ADDR_W:0] : '0) - rewind_len;
    end

    // State registers, length queue and registered read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            frame_start_q <= '0;
            rd_ptr_q      <= '0;
            used_q        <= '0;
            cur_len_q     <= '0;
            rd_cnt_q      <= '0;
            lq_wr_q       <= '0;
            lq_rd_q       <= '0;
            frm_count_q   <= '0;
            tx_data_q     <= '0;
            for (int unsigned i = 0; i < LqDepth; i++) begin
                lenq_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            frame_start_q <= frame_start_d;
            rd_ptr_q      <= rd_ptr_d;
            used_q        <= used_d;
            cur_len_q     <= cur_len_d;
            rd_cnt_q      <= rd_cnt_d;
            lq_wr_q       <= lq_wr_d;
            lq_rd_q       <= lq_rd_d;
            frm_count_q   <= frm_count_d;
            if (push) begin
                lenq_q[lq_wr_q] <= new_len;
            end
            if (rd_en) begin
                tx_data_q <= mem[rd_ptr_q];
            end
        end
    end

    // Data RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_tx_frame_fifo.sv
// Randomized bench for tx_frame_fifo against a queue-based frame model.
module tb_tx_frame_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wr_data = '0;
    logic       wr_valid = 1'b0;
    logic       wr_last = 1'b0;
    logic       wr_ready;
    logic       drop;
    logic       nextByte = 1'b0;
    logic [7:0] tx_data;
    logic [15:0] frm_len;
    logic       empty_buff;
    logic       frm_done = 1'b0;
    logic [2:0] frm_count;

    tx_frame_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_last   (wr_last),
        .wr_ready  (wr_ready),
        .drop      (drop),
        .nextByte  (nextByte),
        .tx_data   (tx_data),
        .frm_len   (frm_len),
        .empty_buff(empty_buff),
        .frm_done  (frm_done),
        .frm_count (frm_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int drop_pulses = 0;

    // Reference model: committed bytes in order (head frame first), frame
    // lengths, bytes already read from the head, last byte handed out.
    byte unsigned mdl_data[$];
    int           mdl_len[$];
    int           mdl_rd = 0;
    logic [7:0]   mdl_tx = '0;
    byte unsigned cur_frame[$];

    always @(negedge clk) begin
        if (rst && drop) drop_pulses++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check_eq({tag, "_count"}, 32'(frm_count), 32'(mdl_len.size()));
        check_eq({tag, "_empty"}, 32'(empty_buff), 32'(mdl_len.size() == 0));
        if (mdl_len.size() != 0) check_eq({tag, "_len"}, 32'(frm_len), 32'(mdl_len[0]));
    endtask

    // Offer a frame byte by byte; records the byte index at which drop was seen.
    task automatic send_frame(input int len, input bit pattern, output int drop_at);
        int guard;
        logic [7:0] b;
        drop_at = -1;
        cur_frame.delete();
        for (int i = 0; i < len; i++) begin
            b = pattern ? 8'(i) : 8'($urandom_range(0, 255));
            wr_data  = b;
            wr_valid = 1'b1;
            wr_last  = (i == len - 1);
            guard    = 0;
            @(negedge clk);
            if (drop && drop_at < 0) drop_at = i;
            while (!wr_ready && guard < 100) begin
                @(negedge clk);
                guard++;
                if (drop && drop_at < 0) drop_at = i;
            end
            if (!wr_ready) begin
                check_eq("wr_ready_timeout", 32'(wr_ready), 32'd1);
                break;
            end
            @(posedge clk);
            #1;
            cur_frame.push_back(b);
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    // A frame that cannot fit while the queue is empty is dropped when the
    // RAM fills, i.e. while the first byte beyond the free space is offered.
    task automatic commit_model(input int len, input int drop_at);
        int free_b;
        bit exp_drop;
        free_b   = 256 - mdl_data.size();
        exp_drop = (len > free_b);
        check_eq("drop_index", 32'(drop_at), exp_drop ? 32'(free_b) : 32'hFFFF_FFFF);
        if (!exp_drop) begin
            foreach (cur_frame[k]) mdl_data.push_back(cur_frame[k]);
            mdl_len.push_back(len);
        end
    endtask

    task automatic read_bytes(input int n);
        if (n == 0) return;
        nextByte = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (mdl_len.size() != 0 && mdl_rd < mdl_len[0]) begin
                mdl_tx = mdl_data[mdl_rd];
                mdl_rd++;
            end
            check_eq("tx_data", 32'(tx_data), 32'(mdl_tx));
        end
        nextByte = 1'b0;
    endtask

    task automatic pop_frame();
        int n;
        frm_done = 1'b1;
        @(posedge clk);
        #1;
        frm_done = 1'b0;
        if (mdl_len.size() != 0) begin
            n = mdl_len.pop_front();
            repeat (n) void'(mdl_data.pop_front());
            mdl_rd = 0;
        end
        check_status("pop");
    endtask

    task automatic send_and_check(input int len, input bit pattern);
        int da;
        send_frame(len, pattern, da);
        commit_model(len, da);
        check_status("commit");
    endtask

    task automatic drain();
        while (mdl_len.size() != 0) begin
            read_bytes(mdl_len[0] - mdl_rd + 1);
            pop_frame();
        end
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic reset_now(input string tag);
        #2 rst = 1'b0;
        #1;
        check_eq({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
        check_eq({tag, "_drop"}, 32'(drop), 32'd0);
        check_eq({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check_eq({tag, "_frm_len"}, 32'(frm_len), 32'd0);
        check_eq({tag, "_empty"}, 32'(empty_buff), 32'd1);
        check_eq({tag, "_count"}, 32'(frm_count), 32'd0);
        mdl_data.delete();
        mdl_len.delete();
        mdl_rd   = 0;
        mdl_tx   = '0;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        nextByte = 1'b0;
        frm_done = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int da;
        int drops_before;
        int len;

        // Power-on reset
        #1 rst = 1'b0;
        #3;
        check_eq("por_wr_ready", 32'(wr_ready), 32'd1);
        check_eq("por_empty", 32'(empty_buff), 32'd1);
        check_eq("por_tx_data", 32'(tx_data), 32'd0);
        check_eq("por_frm_len", 32'(frm_len), 32'd0);
        check_eq("por_count", 32'(frm_count), 32'd0);
        check_eq("por_drop", 32'(drop), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: 64-byte counting frame, one extra strobe, then pop
        send_and_check(64, 1'b1);
        read_bytes(65);
        check_eq("t1_hold", 32'(tx_data), 32'h3F);
        pop_frame();

        // 2: three frames back to back across the RAM wrap
        send_and_check(70, 1'b0);
        send_and_check(100, 1'b0);
        send_and_check(80, 1'b0);
        drain();

        // 3: oversize frame with empty queue is dropped once, then recovery
        drops_before = drop_pulses;
        send_and_check(300, 1'b0);
        check_eq("t3_drop_pulses", 32'(drop_pulses - drops_before), 32'd1);
        send_and_check(10, 1'b0);
        drain();

        // 4: length queue full back-pressures ingress
        repeat (4) send_and_check(10, 1'b0);
        check_eq("t4_full_ready", 32'(wr_ready), 32'd0);
        pop_frame();
        check_eq("t4_ready_after_pop", 32'(wr_ready), 32'd1);
        send_and_check(10, 1'b0);
        drain();

        // 5: pop after a partial read skips the rest of the frame
        send_and_check(20, 1'b0);
        send_and_check(8, 1'b0);
        read_bytes(5);
        pop_frame();
        read_bytes(1);
        drain();

        // 6: reset mid-write, then mid-read, then normal operation
        for (int i = 0; i < 5; i++) begin
            wr_data  = 8'($urandom_range(0, 255));
            wr_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        reset_now("rst_wr");
        send_and_check(12, 1'b0);
        read_bytes(4);
        reset_now("rst_rd");
        send_and_check(16, 1'b0);
        drain();

        // Random mix of commits, partial reads and pops
        for (int it = 0; it < 40; it++) begin
            len = $urandom_range(1, 90);
            if (mdl_len.size() < 4 && mdl_data.size() + len <= 256) begin
                send_frame(len, 1'b0, da);
                commit_model(len, da);
                check_status("rnd_commit");
            end
            if ($urandom_range(0, 1) == 1) read_bytes($urandom_range(0, 24));
            if ($urandom_range(0, 2) == 0) pop_frame();
        end
        drain();
        check_eq("drop_total", 32'(drop_pulses), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
